// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester and data-memory signals shared by the arbiter and its users
interface dmem_arbiter_if #(parameter int ADDR_W = 32);
  logic              r0_req, r1_req;
  logic              r0_we, r1_we;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [2:0]        r0_func3, r1_func3;
  logic [31:0]       r0_wdata, r1_wdata;
  logic              r0_gnt, r1_gnt;
  logic              r0_rvalid, r1_rvalid;
  logic [31:0]       r0_rdata, r1_rdata;
  logic              r0_err, r1_err;
  logic              mem_en, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  modport slave (
    input  r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_func3, r1_func3,
           r0_wdata, r1_wdata, mem_rdata,
    output r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata, r0_err, r1_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
  modport master (
    output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_func3, r1_func3,
           r0_wdata, r1_wdata, mem_rdata,
    input  r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata, r0_err, r1_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-requester data-memory arbiter with byte/half/word sequencing
module dmem_arbiter #(parameter int ADDR_W = 32) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);
  logic              last, g0, g1, gnt, we, legal, en;
  logic [ADDR_W-1:0] a;
  logic [2:0]        f3;
  logic [31:0]       wd, swd;
  logic [3:0]        sbe;
  logic              v, id, err_q, ld;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [7:0]        b;
  logic [15:0]       h;
  logic [31:0]       ext;
  assign g0  = rst && bus.r0_req && (!bus.r1_req || last);
  assign g1  = rst && bus.r1_req && (!bus.r0_req || !last);
  assign gnt = g0 || g1;
  assign we  = g1 ? bus.r1_we    : bus.r0_we;
  assign a   = g1 ? bus.r1_addr  : bus.r0_addr;
  assign f3  = g1 ? bus.r1_func3 : bus.r0_func3;
  assign wd  = g1 ? bus.r1_wdata : bus.r0_wdata;
  // unsigned variants exist only for loads
  assign legal = (f3 == 3'b000) || (f3 == 3'b001 && !a[0]) || (f3 == 3'b010 && a[1:0] == 2'b00) ||
                 (!we && f3 == 3'b100) || (!we && f3 == 3'b101 && !a[0]);
  assign en  = gnt && legal;
  assign sbe = f3[1:0] == 2'b00 ? 4'b0001 << a[1:0] :
               f3[1:0] == 2'b01 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  assign swd = f3[1:0] == 2'b00 ? {4{wd[7:0]}} :
               f3[1:0] == 2'b01 ? {2{wd[15:0]}} : wd;
  assign bus.r0_gnt    = g0;
  assign bus.r1_gnt    = g1;
  assign bus.mem_en    = en;
  assign bus.mem_we    = en && we;
  assign bus.mem_be    = en ? (we ? sbe : 4'b1111) : 4'b0000;
  assign bus.mem_addr  = en ? {a[ADDR_W-1:2], 2'b00} : '0;
  assign bus.mem_wdata = (en && we) ? swd : 32'd0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last  <= 1'b1;
      v     <= 1'b0;
      id    <= 1'b0;
      err_q <= 1'b0;
      ld    <= 1'b0;
      f3_q  <= 3'b000;
      off_q <= 2'b00;
    end else begin
      v <= gnt;
      if (gnt) begin
        last  <= g1;
        id    <= g1;
        err_q <= !legal;
        ld    <= legal && !we;
        f3_q  <= f3;
        off_q <= a[1:0];
      end
    end
  end
  // memory data arrives one cycle after the grant, so extraction uses the registered offset
  assign b   = off_q[1] ? (off_q[0] ? bus.mem_rdata[31:24] : bus.mem_rdata[23:16]) :
                          (off_q[0] ? bus.mem_rdata[15:8]  : bus.mem_rdata[7:0]);
  assign h   = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  assign ext = f3_q[1:0] == 2'b00 ? {{24{!f3_q[2] && b[7]}}, b} :
               f3_q[1:0] == 2'b01 ? {{16{!f3_q[2] && h[15]}}, h} : bus.mem_rdata;
  assign bus.r0_rvalid = v && !id;
  assign bus.r1_rvalid = v && id;
  assign bus.r0_err    = v && !id && err_q;
  assign bus.r1_err    = v && id && err_q;
  assign bus.r0_rdata  = (v && !id && ld) ? ext : 32'd0;
  assign bus.r1_rdata  = (v && id && ld) ? ext : 32'd0;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the single-port data memory. Shares the memory between the core MEM stage (requester 0) and the FPU load/store unit (requester 1) with round-robin arbitration. Converts RISC-V func3 byte/half/word accesses into byte-enabled word accesses, and returns sign- or zero-extended load data one cycle later.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `r0_req`, `r1_req` in 1: access request.
- `r0_we`, `r1_we` in 1: 1 = store, 0 = load.
- `r0_addr`, `r1_addr` in ADDR_W: byte address.
- `r0_func3`, `r1_func3` in 3: access size/sign (RISC-V load/store func3).
- `r0_wdata`, `r1_wdata` in 32: store data, right-aligned.
- `r0_gnt`, `r1_gnt` out 1: request accepted this cycle.
- `r0_rvalid`, `r1_rvalid` out 1: response for an access granted last cycle.
- `r0_rdata`, `r1_rdata` out 32: load result; 0 for stores and errors.
- `r0_err`, `r1_err` out 1: response is an illegal/misaligned access; valid with rvalid.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write.
- `mem_be` out 4: byte enables.
- `mem_addr` out ADDR_W: word-aligned address, [1:0] = 0.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: read data, valid the cycle after `mem_en && !mem_we`.

## Operation
- Requester rule: `req`, `we`, `addr`, `func3` and `wdata` are held stable until `gnt`.
- Arbitration:
  - At most one grant per cycle.
  - A lone request is always granted with no bubble.
  - When both requesters assert `req`, the one not granted last wins.
  - Register `last` updates on every grant; reset value 1, so r0 wins the first tie.
- Legality:
  - func3 values: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
  - 100 and 101 with `we` = 1 are illegal. 011, 110 and 111 are illegal.
  - Misaligned: half with addr[0] = 1; word with addr[1:0] ≠ 0.
  - An illegal or misaligned access is still granted, but `mem_en` = 0.
  - Its response has `err` = 1 and `rdata` = 0.
- Store mapping:
  - Byte: `be` = 0001 << addr[1:0], `wdata` = {4{wdata[7:0]}}.
  - Half: `be` = 0011 << (2·addr[1]), `wdata` = {2{wdata[15:0]}}.
  - Word: `be` = 1111, `wdata` unchanged.
- Load: `mem_be` = 1111. Requester id, func3 and addr[1:0] are registered into a one-deep response stage.
- Load extraction: select the byte/half at the registered offset. Sign-extend for 000/001; zero-extend for 100/101.
- Response stage:
  - Every grant, legal or not, load or store, produces exactly one `rvalid` pulse to the granted requester, the next cycle.
  - Store responses carry `rdata` = 0, `err` = 0.
- Idle: `mem_en`, `mem_we`, `mem_be`, `mem_addr` and `mem_wdata` are all 0 when nothing is granted.

## Timing
- `gnt` and `mem_*` are combinational from `req` and `last`, in the same cycle.
- `rvalid`, `rdata` and `err` are registered: exactly 1 cycle after `gnt`.
- Throughput is 1 access/cycle sustained. `r0_rvalid` and `r1_rvalid` are never high together.
- Reset (`rst` = 0), immediate and asynchronous:
  - `gnt` and `mem_en` are forced to 0.
  - `rvalid`, `rdata` and `err` clear to 0.
  - `last` = 1.
- Reset mid-operation: a response pending from a grant in the cycle before `rst` falls is dropped, with no `rvalid` after release.
- First cycle after release: normal arbitration.

## Test plan
- Reset and tie:
  - Stimulus: hold `rst` = 0; then release and drive r0 and r1 load requests in the same cycle.
  - Response: all outputs 0 during reset. `r0_gnt` in cycle 1, `r1_gnt` in cycle 2, `rvalid` to each one cycle after its grant.
- Byte store:
  - Stimulus: r0 SB, `addr` 0x103, `wdata` 0x000000A5.
  - Response: `mem_addr` 0x100, `mem_be` 1000, `mem_wdata` 0xA5A5A5A5, `mem_we` 1. Next cycle `r0_rvalid` = 1, `err` = 0, `rdata` = 0.
- Load extension, with `mem_rdata` = 0x12F45678, all at `addr` 0x102:
  - LB → 0xFFFFFFF4.
  - LBU → 0x000000F4.
  - LH → 0x000012F4.
  - LHU → 0x000012F4.
  - LW at 0x100 → 0x12F45678.
- Errors:
  - r1 LW at 0x106 → `r1_gnt` = 1 and `mem_en` = 0. Next cycle `r1_rvalid` = 1, `r1_err` = 1, `r1_rdata` = 0.
  - func3 111 → same error response.
- Contention: both requesters request continuously for 6 cycles → grants r0, r1, r0, r1, r0, r1, and `rvalid` alternates one cycle later.
- Reset during load: drop `rst` the cycle after an r1 load grant → no `r1_rvalid` after release, and the next tie goes to r0.
